// File: rtl/elevator_shaft_model.sv
// Behavioural model of one elevator car in its shaft: position, floor sensors,
// motion/door state machine and sticky safety-error flags.
module elevator_shaft_model #(
    parameter int TRAVEL_CYCLES = 3,
    parameter int DOOR_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       stop,
    input  logic       open_door,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic       S4,
    output logic [1:0] floor,
    output logic       moving,
    output logic       door_open,
    output logic       limit_err,
    output logic       interlock_err,
    output logic [1:0] state_dbg
);

    // Commands are plain levels sampled on every rising clk; there is no
    // valid/ready handshake, the controller simply holds what it wants.

    localparam int MAX_POS = 3 * TRAVEL_CYCLES;
    localparam int POS_W   = $clog2(MAX_POS + 1);

    localparam logic [POS_W-1:0] P0 = '0;
    localparam logic [POS_W-1:0] P1 = POS_W'(TRAVEL_CYCLES);
    localparam logic [POS_W-1:0] P2 = POS_W'(2 * TRAVEL_CYCLES);
    localparam logic [POS_W-1:0] P3 = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] ONE = POS_W'(1);
    localparam logic [3:0] DOOR_LIM = 4'(DOOR_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DOOR = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [1:0]       floor_q, floor_d;
    logic [3:0]       door_cnt_q, door_cnt_d;
    logic             limit_err_q, limit_err_d;
    logic             interlock_err_q, interlock_err_d;

    function automatic logic is_aligned(input logic [POS_W-1:0] p);
        return (p == P0) || (p == P1) || (p == P2) || (p == P3);
    endfunction

    function automatic logic [1:0] floor_of(input logic [POS_W-1:0] p);
        logic [1:0] f;
        f = 2'd0;
        if (p == P1) f = 2'd1;
        if (p == P2) f = 2'd2;
        if (p == P3) f = 2'd3;
        return f;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            pos_q           <= '0;
            floor_q         <= 2'd0;
            door_cnt_q      <= 4'd0;
            limit_err_q     <= 1'b0;
            interlock_err_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pos_q           <= pos_d;
            floor_q         <= floor_d;
            door_cnt_q      <= door_cnt_d;
            limit_err_q     <= limit_err_d;
            interlock_err_q <= interlock_err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pos_d           = pos_q;
        door_cnt_d      = door_cnt_q;
        limit_err_d     = limit_err_q;
        interlock_err_d = interlock_err_q;

        if (up && down) interlock_err_d = 1'b1;

        case (state_q)
            IDLE: begin
                door_cnt_d = 4'd0;
                if (open_door) begin
                    if (is_aligned(pos_q)) state_d = DOOR;
                end else if (!(up && down) && !stop) begin
                    if (up) begin
                        if (pos_q == P3) begin
                            limit_err_d = 1'b1;
                        end else begin
                            state_d = UP;
                            pos_d   = pos_q + ONE;
                        end
                    end else if (down) begin
                        if (pos_q == P0) begin
                            limit_err_d = 1'b1;
                        end else begin
                            state_d = DOWN;
                            pos_d   = pos_q - ONE;
                        end
                    end
                end
            end
            UP: begin
                // Commands only matter at alignment; between floors the car coasts.
                pos_d = (pos_q == P3) ? pos_q : pos_q + ONE;
                if (is_aligned(pos_d) && ((pos_d == P3) || !up || stop))
                    state_d = IDLE;
            end
            DOWN: begin
                pos_d = (pos_q == P0) ? pos_q : pos_q - ONE;
                if (is_aligned(pos_d) && ((pos_d == P0) || !down || stop))
                    state_d = IDLE;
            end
            DOOR: begin
                if (up || down) interlock_err_d = 1'b1;
                if (open_door) begin
                    door_cnt_d = 4'd0;
                end else begin
                    door_cnt_d = (door_cnt_q == 4'hF) ? door_cnt_q : door_cnt_q + 4'd1;
                    if (door_cnt_d >= DOOR_LIM) begin
                        state_d    = IDLE;
                        door_cnt_d = 4'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        floor_d = is_aligned(pos_d) ? floor_of(pos_d) : floor_q;
    end

    assign S1            = (pos_q == P0);
    assign S2            = (pos_q == P1);
    assign S3            = (pos_q == P2);
    assign S4            = (pos_q == P3);
    assign floor         = floor_q;
    assign moving        = (state_q == UP) || (state_q == DOWN);
    assign door_open     = (state_q == DOOR);
    assign limit_err     = limit_err_q;
    assign interlock_err = interlock_err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_elevator_shaft_model.sv
// Scoreboard bench for elevator_shaft_model: directed scenarios plus random
// command streams, compared against a floor/direction-level reference model.
module tb_elevator_shaft_model;

    localparam int TC  = 3;
    localparam int DC  = 2;
    localparam int MAX = 3 * TC;
    localparam logic [9:0] RST_VEC = 10'b1000_00_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       up = 1'b0, down = 1'b0, stop = 1'b0, open_door = 1'b0;
    logic       S1, S2, S3, S4, moving, door_open, limit_err, interlock_err;
    logic [1:0] floor, state_dbg;
    logic [9:0] dut_vec;

    logic [9:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // reference model: position in travel steps, direction -1/0/+1, door flag
    int m_pos, m_dir, m_dcnt, m_floor;
    bit m_door, m_lim, m_ilk;

    elevator_shaft_model #(.TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .up(up), .down(down), .stop(stop),
        .open_door(open_door), .S1(S1), .S2(S2), .S3(S3), .S4(S4),
        .floor(floor), .moving(moving), .door_open(door_open),
        .limit_err(limit_err), .interlock_err(interlock_err),
        .state_dbg(state_dbg)
    );

    assign dut_vec = {S1, S2, S3, S4, floor, moving, door_open, limit_err, interlock_err};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_reset();
        m_pos = 0; m_dir = 0; m_dcnt = 0; m_floor = 0;
        m_door = 0; m_lim = 0; m_ilk = 0;
    endfunction

    function automatic logic [9:0] model_out();
        logic [1:0] f;
        f = 2'(m_floor);
        return {m_pos == 0, m_pos == TC, m_pos == 2 * TC, m_pos == MAX,
                f, m_dir != 0, m_door, m_lim, m_ilk};
    endfunction

    function automatic void model_step(bit u, bit d, bit s, bit o);
        if (u && d) m_ilk = 1;
        if (m_door) begin
            if (u || d) m_ilk = 1;
            if (o) m_dcnt = 0;
            else begin
                m_dcnt++;
                if (m_dcnt >= DC) begin m_door = 0; m_dcnt = 0; end
            end
        end else if (m_dir != 0) begin
            m_pos += m_dir;
            if (m_pos % TC == 0) begin
                if (m_pos == MAX || m_pos == 0) m_dir = 0;
                else if (s || (m_dir > 0 ? !u : !d)) m_dir = 0;
            end
        end else begin
            if (o) begin m_door = 1; m_dcnt = 0; end
            else if (!(u && d) && !s) begin
                if (u) begin
                    if (m_pos == MAX) m_lim = 1;
                    else begin m_dir = 1; m_pos++; end
                end else if (d) begin
                    if (m_pos == 0) m_lim = 1;
                    else begin m_dir = -1; m_pos--; end
                end
            end
        end
        if (m_pos % TC == 0) m_floor = m_pos / TC;
    endfunction

    // driver: apply one cycle of commands and queue the expected result
    task automatic step(input bit u, input bit d, input bit s, input bit o);
        @(negedge clk);
        up = u; down = d; stop = s; open_door = o;
        model_step(u, d, s, o);
        exp_q.push_back(model_out());
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        up = 0; down = 0; stop = 0; open_door = 0;
        #1;
        check("async_reset", 32'(dut_vec), 32'(RST_VEC));
        model_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset_release", 32'(dut_vec), 32'(RST_VEC));
    endtask

    // monitor: every clock edge that has an expectation queued is compared
    always @(posedge clk) begin
        cyc++;
        #1;
        if (exp_q.size() > 0) begin
            logic [9:0] e;
            e = exp_q.pop_front();
            check($sformatf("cycle %0d", cyc), 32'(dut_vec), 32'(e));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // full run to the top floor, then one more up at the limit
        repeat (10) step(1, 0, 0, 0);
        @(posedge clk); #2;
        check("top_floor", 32'(floor), 32'd3);
        check("top_limit", 32'(limit_err), 32'd1);

        // single-cycle up pulse coasts to floor 2 and stays
        do_reset();
        step(1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        @(posedge clk); #2;
        check("coast_S2", 32'(S2), 32'd1);

        // door at floor 2 with up asserted, then close and leave
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        @(posedge clk); #2;
        check("door_then_move", 32'(moving), 32'd1);

        // up and down together at floor 1
        do_reset();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);

        // reset mid-travel at pos 4
        do_reset();
        repeat (4) step(1, 0, 0, 0);
        do_reset();

        // reversal and stop between floors must not halt the car
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0);

        // random command streams, each segment from a fresh reset
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int i = 0; i < 150; i++) begin
                bit u, d, s, o;
                u = ($urandom_range(0, 99) < 45);
                d = ($urandom_range(0, 99) < 35);
                s = ($urandom_range(0, 99) < 10);
                o = ($urandom_range(0, 99) < 10);
                if (seg < 3 && u) d = 0;
                step(u, d, s, o);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/elevator_shaft_model.md
ELEVATOR_SHAFT_MODEL -- requirements
Module: elevator_shaft_model

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 3, SHALL set the clock cycles of motion between adjacent floors (legal 2..15).
REQ-002 Parameter DOOR_CYCLES, default 2, SHALL set the consecutive cycles of open_door low needed to close the door (legal 1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 up  input  1  SHALL be the motor up command from the controller.
REQ-006 down  input  1  SHALL be the motor down command.
REQ-007 stop  input  1  SHALL be the brake command; it overrides up/down.
REQ-008 open_door  input  1  SHALL be the door open request.
REQ-009 S1, S2, S3, S4  output  1 each  SHALL be the floor alignment sensors, one-hot when aligned, all 0 between floors.
REQ-010 floor  output  2  SHALL be the last aligned floor, 0-based (0 = floor 1).
REQ-011 moving  output  1  SHALL be 1 in states UP and DOWN.
REQ-012 door_open  output  1  SHALL be 1 in state DOOR.
REQ-013 limit_err  output  1  SHALL be sticky; set on a drive command past floor 4 or below floor 1.
REQ-014 interlock_err  output  1  SHALL be sticky; set on up or down while door_open=1, or up and down both 1.

Function
REQ-015 Car position SHALL be held in register pos, range 0..3*TRAVEL_CYCLES; floor k is aligned when pos == (k-1)*TRAVEL_CYCLES.
REQ-016 S1..S4 SHALL be a decode of registered pos only; floor SHALL update on the edge that makes pos aligned.
REQ-017 States SHALL be IDLE, UP, DOWN, DOOR.
REQ-018 IDLE -> UP when up=1, down=0, stop=0, open_door=0 and pos < max; the same edge SHALL increment pos.
REQ-019 IDLE -> DOWN when down=1, up=0, stop=0, open_door=0 and pos > 0; the same edge SHALL decrement pos.
REQ-020 IDLE -> DOOR when open_door=1 and pos is aligned; open_door SHALL take priority over up/down in IDLE.
REQ-021 UP/DOWN SHALL step pos by 1 per cycle; on reaching an aligned pos, the car SHALL return to IDLE if the command in its direction is 0 or stop=1, else continue.
REQ-022 Between floors, stop, command drop or reversal SHALL NOT halt the car; it SHALL coast to the next aligned pos in the current direction, then obey IDLE rules.
REQ-023 UP SHALL be forced to IDLE at pos max; DOWN SHALL be forced to IDLE at pos 0.
REQ-024 up=1 (stop=0) while IDLE at pos max, or down=1 (stop=0) while IDLE at pos 0, SHALL set limit_err and cause no motion.
REQ-025 up=1 and down=1 together in IDLE SHALL cause no motion and SHALL set interlock_err.
REQ-026 DOOR SHALL ignore up/down; either asserted in DOOR SHALL set interlock_err.
REQ-027 DOOR SHALL count consecutive cycles with open_door=0, resetting the count on open_door=1, and go to IDLE when the count reaches DOOR_CYCLES.
REQ-028 pos SHALL never leave 0..max; counters SHALL saturate, never wrap.
REQ-029 Sticky error flags SHALL clear only on reset.

Reset
REQ-030 reset=0 SHALL immediately, without clk, force state IDLE, pos 0, floor 0, S1=1, S2..S4=0, moving=0, door_open=0, limit_err=0, interlock_err=0 and door count 0.
REQ-031 Release of reset SHALL be synchronous-safe; the first state change SHALL occur no earlier than the first rising clk after reset=1.
REQ-032 Reset asserted mid-travel or with the door open SHALL abort the operation and return to the REQ-030 values.

Verification (TRAVEL_CYCLES=3, DOOR_CYCLES=2)
REQ-033 Release reset, idle inputs -> S1=1, floor=0, moving=0, door_open=0, both error flags 0.
REQ-034 Hold up=1 from floor 1 for 9 edges -> S1=0 after edge 1, S2=1 after edge 3, S3=1 after edge 6, S4=1/floor=3 after edge 9, moving=0 after edge 9, limit_err=1 after edge 10 if up still held.
REQ-035 1-cycle up pulse at floor 1 -> car coasts; S2=1 and moving=0 after edge 3; pos then stable.
REQ-036 At floor 2, open_door=1 for 2 cycles, up=1 during DOOR -> door_open=1, interlock_err=1, no motion; open_door=0 for 2 edges -> door_open=0; next edge with up=1 -> moving=1.
REQ-037 up=1 and down=1 at floor 1 -> pos unchanged, interlock_err=1, limit_err=0.
REQ-038 Assert reset=0 between clk edges at pos 4 while moving -> S1=1, moving=0, floor=0 before the next edge.
